// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv
// gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog
//   Programmable clock divider / clock-enable generator. From CLK it derives a
//   registered divided clock Z (high for H=(N+1)>>1 cycles, low for N-H cycles)
//   and a one-cycle strobe ZP in the first cycle of every Z period. The ratio N
//   can be reloaded at runtime; while running, a new ratio is held pending and
//   only takes effect at a period boundary, so Z never produces a runt pulse
//   except when RST cuts a period short.
//
// Ports
//   CLK    in   clock, all state updates on the rising edge
//   RST    in   synchronous active-high reset, overrides every other input
//   EN     in   run request; dropping it lets the current period finish
//   DIV    in   requested ratio (values below 2 are clamped to 2), sampled on LD
//   LD     in   load strobe for DIV
//   Z      out  divided clock, registered
//   ZP     out  one-cycle pulse in the first cycle of each Z period, registered
//   DIV_Q  out  ratio currently in effect
//   BUSY   out  a loaded ratio is waiting for the next period boundary
//
// Handshake: LD is a one-cycle strobe with no back-pressure. BUSY only reports
// that a ratio is pending; a new LD while BUSY simply replaces the pending ratio.
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog #(
    parameter int W       = 8,
    parameter int RST_DIV = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [W-1:0] DIV,
    input  logic         LD,
    output logic         Z,
    output logic         ZP,
    output logic [W-1:0] DIV_Q,
    output logic         BUSY
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Reset ratio, clamped the same way as a runtime load.
    localparam logic [W-1:0] RST_N = (RST_DIV < 2) ? W'(2) : W'(RST_DIV);

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
        return (v < W'(2)) ? W'(2) : v;
    endfunction

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic         z_q, z_nxt;
    logic         zp_q, zp_nxt;
    logic [W-1:0] div_q, div_q_nxt;
    logic [W-1:0] pend, pend_nxt;
    logic         busy, busy_nxt;

    logic         wrap;
    logic [W-1:0] cnt_p1;
    logic [W:0]   high_len;

    // Last cycle of the current period. div_q is always >= 2, so div_q-1
    // cannot underflow.
    assign wrap     = (cnt == div_q - W'(1));
    assign cnt_p1   = cnt + W'(1);
    // Computed one bit wider so N = 2^W-1 does not overflow.
    assign high_len = ({1'b0, div_q} + (W+1)'(1)) >> 1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            z_q   <= 1'b0;
            zp_q  <= 1'b0;
            div_q <= RST_N;
            pend  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            z_q   <= z_nxt;
            zp_q  <= zp_nxt;
            div_q <= div_q_nxt;
            pend  <= pend_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        z_nxt     = 1'b0;
        zp_nxt    = 1'b0;
        div_q_nxt = div_q;
        pend_nxt  = pend;
        busy_nxt  = busy;

        case (state)
            IDLE: begin
                cnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (LD) begin
                    div_q_nxt = clamp(DIV);
                end else if (busy) begin
                    // A load that landed on the stopping edge is still
                    // pending; nothing is running, so apply it right away.
                    div_q_nxt = pend;
                end
                if (EN) begin
                    state_nxt = RUN;
                    z_nxt     = 1'b1;
                    zp_nxt    = 1'b1;
                end
            end

            RUN: begin
                if (wrap) begin
                    // Period boundary: the pending ratio takes effect here so
                    // the next period is generated entirely with the new N.
                    if (busy) begin
                        div_q_nxt = pend;
                        busy_nxt  = 1'b0;
                    end
                    cnt_nxt = '0;
                    if (EN) begin
                        z_nxt  = 1'b1;
                        zp_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_p1;
                    z_nxt   = ({1'b0, cnt_p1} < high_len);
                end
                // Evaluated after the boundary update so a load on the wrap
                // edge becomes the next pending ratio rather than being lost.
                if (LD) begin
                    pend_nxt = clamp(DIV);
                    busy_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign Z     = z_q;
    assign ZP    = zp_q;
    assign DIV_Q = div_q;
    assign BUSY  = busy;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv
// Directed testbench for gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog (W=8, RST_DIV=2).
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// i.e. they reflect the edge just taken.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] div;
  logic         ld;
  logic         z;
  logic         zp;
  logic [W-1:0] div_q;
  logic         busy;

  int n_cmp;
  int n_err;

  gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog #(
    .W       (W),
    .RST_DIV (2)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .EN    (en),
    .DIV   (div),
    .LD    (ld),
    .Z     (z),
    .ZP    (zp),
    .DIV_Q (div_q),
    .BUSY  (busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ez, input logic ezp,
                     input logic [W-1:0] edq, input logic eb);
    n_cmp++;
    assert (z === ez && zp === ezp && div_q === edq && busy === eb)
    else begin
      n_err++;
      $error("FAIL %s: got Z=%b ZP=%b DIV_Q=%0d BUSY=%b, expected Z=%b ZP=%b DIV_Q=%0d BUSY=%b",
             tag, z, zp, div_q, busy, ez, ezp, edq, eb);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ld = 1'b0; div = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] v);
    ld = 1'b1; div = v;
    tick();
    ld = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b0; ld = 1'b0; div = '0;

    // 1: reset state, then default N=2 -> Z/ZP = 1,0,1,0
    tick();
    chk("t1_reset", 1'b0, 1'b0, 8'd2, 1'b0);
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t1_n2", (i % 2) == 0, (i % 2) == 0, 8'd2, 1'b0);
    end

    // 2: load 5 in IDLE, then run -> 1,1,1,0,0
    do_reset();
    load(8'd5);
    chk("t2_idle_load", 1'b0, 1'b0, 8'd5, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_n5", (i % 5) < 3, (i % 5) == 0, 8'd5, 1'b0);
    end

    // 3: N=4 running, load 3 at cnt=1 -> period 1,1,0,0 then 1,1,0
    do_reset();
    load(8'd4);
    en = 1'b1;
    tick();
    chk("t3_c0", 1'b1, 1'b1, 8'd4, 1'b0);
    load(8'd3);
    chk("t3_c1", 1'b1, 1'b0, 8'd4, 1'b1);
    tick();
    chk("t3_c2", 1'b0, 1'b0, 8'd4, 1'b1);
    tick();
    chk("t3_c3", 1'b0, 1'b0, 8'd4, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t3_n3", (i % 3) < 2, (i % 3) == 0, 8'd3, 1'b0);
    end

    // 4: N=6, EN drops at cnt=1 -> period completes, then idle; re-enable
    do_reset();
    load(8'd6);
    en = 1'b1;
    tick();
    chk("t4_c0", 1'b1, 1'b1, 8'd6, 1'b0);
    en = 1'b0;
    for (int i = 1; i < 6; i++) begin
      tick();
      chk("t4_finish", i < 3, 1'b0, 8'd6, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_stopped", 1'b0, 1'b0, 8'd6, 1'b0);
    end
    en = 1'b1;
    tick();
    chk("t4_restart", 1'b1, 1'b1, 8'd6, 1'b0);

    // 5: clamps and the widest ratio
    do_reset();
    load(8'd7);
    chk("t5_ld7", 1'b0, 1'b0, 8'd7, 1'b0);
    load(8'd0);
    chk("t5_ld0", 1'b0, 1'b0, 8'd2, 1'b0);
    load(8'd7);
    load(8'd1);
    chk("t5_ld1", 1'b0, 1'b0, 8'd2, 1'b0);
    load(8'd255);
    en = 1'b1;
    for (int i = 0; i < 257; i++) begin
      tick();
      chk("t5_n255", (i % 255) < 128, (i % 255) == 0, 8'd255, 1'b0);
    end

    // 6: reset at cnt=2 of N=5 with a pending load and EN held
    do_reset();
    load(8'd5);
    en = 1'b1;
    tick();
    chk("t6_c0", 1'b1, 1'b1, 8'd5, 1'b0);
    load(8'd3);
    chk("t6_c1", 1'b1, 1'b0, 8'd5, 1'b1);
    tick();
    chk("t6_c2", 1'b1, 1'b0, 8'd5, 1'b1);
    rst = 1'b1;
    tick();
    chk("t6_rst", 1'b0, 1'b0, 8'd2, 1'b0);
    tick();
    chk("t6_rst_hold", 1'b0, 1'b0, 8'd2, 1'b0);
    rst = 1'b0;
    tick();
    chk("t6_restart", 1'b1, 1'b1, 8'd2, 1'b0);

    // 7: last load wins, and a load on the wrap edge
    do_reset();
    load(8'd4);
    en = 1'b1;
    tick();
    load(8'd7);
    chk("t7_pend7", 1'b1, 1'b0, 8'd4, 1'b1);
    load(8'd3);
    chk("t7_pend3", 1'b0, 1'b0, 8'd4, 1'b1);
    tick();
    load(8'd5);
    chk("t7_wrap_ld", 1'b1, 1'b1, 8'd3, 1'b1);
    tick();
    chk("t7_c1", 1'b1, 1'b0, 8'd3, 1'b1);
    tick();
    chk("t7_c2", 1'b0, 1'b0, 8'd3, 1'b1);
    tick();
    chk("t7_wrap2", 1'b1, 1'b1, 8'd5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
